// File: rtl/svm_pkg.sv
// Shared widths, controller states and helpers for the SVM host driver.
package svm_pkg;

  function automatic int ceilLog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int NBITS           = 9;
  localparam int VSUP_WIDTH      = 120;
  localparam int ASUP_WIDTH      = 155;
  localparam int F_WIDTH         = 214;
  localparam int LOG_SUP_WIDTH   = ceilLog2((VSUP_WIDTH > ASUP_WIDTH) ? VSUP_WIDTH : ASUP_WIDTH);
  localparam int ADDR_WIDTH      = 8;
  localparam int VSUP_BITS       = NBITS * VSUP_WIDTH;
  localparam int ASUP_BITS       = NBITS * ASUP_WIDTH;
  localparam int FEAT_BITS       = NBITS * F_WIDTH;
  localparam int INTERCEPT_WIDTH = 2 * NBITS + LOG_SUP_WIDTH;

  typedef enum logic [2:0] {
    IDLE_UNLOADED,
    LOAD,
    DONE,
    READY,
    SEND_V,
    SEND_A,
    WAIT_RES,
    HOLD
  } state_t;

endpackage

// File: rtl/svm_rom_loader.sv
// Streams DEPTH rows from a synchronous ROM into an SRAM write port,
// pausing without skipping or repeating addresses whenever the sink is not ready.
module svm_rom_loader
  import svm_pkg::*;
#(
  parameter int DEPTH = 214,
  parameter int AW    = ADDR_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          write_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          we,
  output logic [AW-1:0] wr_addr,
  output logic          last_write
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic          active;
  logic [AW-1:0] rd_cnt;

  assign rd_en   = active && write_ready;
  assign rd_addr = rd_cnt;

  // The write side trails the read side by the ROM's one-cycle latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active     <= 1'b0;
      rd_cnt     <= '0;
      we         <= 1'b0;
      wr_addr    <= '0;
      last_write <= 1'b0;
    end else begin
      if (start) begin
        active <= 1'b1;
        rd_cnt <= '0;
      end else if (rd_en) begin
        if (rd_cnt == LAST) active <= 1'b0;
        else                rd_cnt <= rd_cnt + 1'b1;
      end
      we         <= rd_en;
      if (rd_en) wr_addr <= rd_cnt;
      last_write <= rd_en && (rd_cnt == LAST);
    end
  end

endmodule

// File: rtl/svm_host_driver.sv
// Host-side initiator for the SVM core: loads the model from ROM, then
// feeds one valence/arousal feature pair at a time and buffers the result.
module svm_host_driver
  import svm_pkg::*;
#(
  parameter int MEM_DEPTH = 214
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       svm_rst,
  input  logic                       load_start,
  output logic                       loaded,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  output logic                       rom_rd_en,
  input  logic [VSUP_BITS-1:0]       rom_v_support,
  input  logic [NBITS-1:0]           rom_v_alpha,
  input  logic [ASUP_BITS-1:0]       rom_a_support,
  input  logic [NBITS-1:0]           rom_a_alpha,
  input  logic [INTERCEPT_WIDTH-1:0] cfg_v_intercept,
  input  logic [INTERCEPT_WIDTH-1:0] cfg_a_intercept,
  output logic [VSUP_BITS-1:0]       v_in_support,
  output logic [NBITS-1:0]           v_in_alpha,
  output logic [ASUP_BITS-1:0]       a_in_support,
  output logic [NBITS-1:0]           a_in_alpha,
  output logic [INTERCEPT_WIDTH-1:0] v_in_intercept,
  output logic [INTERCEPT_WIDTH-1:0] a_in_intercept,
  output logic [ADDR_WIDTH-1:0]      mem_write_addr,
  output logic                       mem_we,
  input  logic                       mem_write_ready,
  output logic                       mem_write_done,
  output logic                       intercept_valid,
  input  logic [FEAT_BITS-1:0]       feat_v,
  input  logic [FEAT_BITS-1:0]       feat_a,
  input  logic                       feat_valid,
  output logic                       feat_ready,
  output logic [FEAT_BITS-1:0]       in_features,
  output logic                       fin_valid,
  input  logic                       fin_ready,
  input  logic                       valence,
  input  logic                       arousal,
  input  logic                       dout_valid,
  output logic                       res_valence,
  output logic                       res_arousal,
  output logic                       res_valid,
  input  logic                       res_ready
);

  if (MEM_DEPTH < 1 || MEM_DEPTH > 256) begin : g_bad_depth
    $error("svm_host_driver: MEM_DEPTH must be in 1..256");
  end

  state_t               state_q, state_d;
  logic                 loader_start;
  logic                 last_write;
  logic [FEAT_BITS-1:0] feat_v_q, feat_a_q;
  logic                 res_valence_q, res_arousal_q;

  assign svm_rst      = ~rst_n;
  assign loader_start = (state_q == IDLE_UNLOADED) && load_start && mem_write_ready;

  svm_rom_loader #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_WIDTH)
  ) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (loader_start),
    .write_ready (mem_write_ready),
    .rd_en       (rom_rd_en),
    .rd_addr     (rom_addr),
    .we          (mem_we),
    .wr_addr     (mem_write_addr),
    .last_write  (last_write)
  );

  // ROM data goes straight to the core; masked so the bus idles at zero.
  assign v_in_support = mem_we ? rom_v_support : '0;
  assign v_in_alpha   = mem_we ? rom_v_alpha   : '0;
  assign a_in_support = mem_we ? rom_a_support : '0;
  assign a_in_alpha   = mem_we ? rom_a_alpha   : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE_UNLOADED;
      feat_v_q      <= '0;
      feat_a_q      <= '0;
      res_valence_q <= 1'b0;
      res_arousal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == READY && feat_valid) begin
        feat_v_q <= feat_v;
        feat_a_q <= feat_a;
      end
      if (state_q == WAIT_RES && dout_valid) begin
        res_valence_q <= valence;
        res_arousal_q <= arousal;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    loaded          = 1'b0;
    mem_write_done  = 1'b0;
    intercept_valid = 1'b0;
    feat_ready      = 1'b0;
    fin_valid       = 1'b0;
    in_features     = '0;
    res_valid       = 1'b0;
    v_in_intercept  = '0;
    a_in_intercept  = '0;
    res_valence     = res_valence_q;
    res_arousal     = res_arousal_q;

    // Intercepts stay on the bus from the end-of-load strobe onward.
    if (state_q != IDLE_UNLOADED && state_q != LOAD) begin
      v_in_intercept = cfg_v_intercept;
      a_in_intercept = cfg_a_intercept;
    end

    case (state_q)
      IDLE_UNLOADED: if (load_start && mem_write_ready) state_d = LOAD;
      LOAD:          if (last_write) state_d = DONE;
      DONE: begin
        mem_write_done  = 1'b1;
        intercept_valid = 1'b1;
        state_d         = READY;
      end
      READY: begin
        loaded     = 1'b1;
        feat_ready = 1'b1;
        if (feat_valid) state_d = SEND_V;
      end
      SEND_V: begin
        loaded      = 1'b1;
        fin_valid   = 1'b1;
        in_features = feat_v_q;
        if (fin_ready) state_d = SEND_A;
      end
      SEND_A: begin
        loaded      = 1'b1;
        fin_valid   = 1'b1;
        in_features = feat_a_q;
        if (fin_ready) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        loaded = 1'b1;
        if (dout_valid) state_d = HOLD;
      end
      HOLD: begin
        loaded    = 1'b1;
        res_valid = 1'b1;
        if (res_ready) state_d = READY;
      end
      default: state_d = IDLE_UNLOADED;
    endcase
  end

endmodule

// File: tb/tb_svm_host_driver.sv
// Directed bench for svm_host_driver with a four-row model.
module tb_svm_host_driver;
  import svm_pkg::*;

  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       svm_rst;
  logic                       load_start;
  logic                       loaded;
  logic [ADDR_WIDTH-1:0]      rom_addr;
  logic                       rom_rd_en;
  logic [VSUP_BITS-1:0]       rom_v_support;
  logic [NBITS-1:0]           rom_v_alpha;
  logic [ASUP_BITS-1:0]       rom_a_support;
  logic [NBITS-1:0]           rom_a_alpha;
  logic [INTERCEPT_WIDTH-1:0] cfg_v_intercept;
  logic [INTERCEPT_WIDTH-1:0] cfg_a_intercept;
  logic [VSUP_BITS-1:0]       v_in_support;
  logic [NBITS-1:0]           v_in_alpha;
  logic [ASUP_BITS-1:0]       a_in_support;
  logic [NBITS-1:0]           a_in_alpha;
  logic [INTERCEPT_WIDTH-1:0] v_in_intercept;
  logic [INTERCEPT_WIDTH-1:0] a_in_intercept;
  logic [ADDR_WIDTH-1:0]      mem_write_addr;
  logic                       mem_we;
  logic                       mem_write_ready;
  logic                       mem_write_done;
  logic                       intercept_valid;
  logic [FEAT_BITS-1:0]       feat_v;
  logic [FEAT_BITS-1:0]       feat_a;
  logic                       feat_valid;
  logic                       feat_ready;
  logic [FEAT_BITS-1:0]       in_features;
  logic                       fin_valid;
  logic                       fin_ready;
  logic                       valence;
  logic                       arousal;
  logic                       dout_valid;
  logic                       res_valence;
  logic                       res_arousal;
  logic                       res_valid;
  logic                       res_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  svm_host_driver #(.MEM_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .svm_rst         (svm_rst),
    .load_start      (load_start),
    .loaded          (loaded),
    .rom_addr        (rom_addr),
    .rom_rd_en       (rom_rd_en),
    .rom_v_support   (rom_v_support),
    .rom_v_alpha     (rom_v_alpha),
    .rom_a_support   (rom_a_support),
    .rom_a_alpha     (rom_a_alpha),
    .cfg_v_intercept (cfg_v_intercept),
    .cfg_a_intercept (cfg_a_intercept),
    .v_in_support    (v_in_support),
    .v_in_alpha      (v_in_alpha),
    .a_in_support    (a_in_support),
    .a_in_alpha      (a_in_alpha),
    .v_in_intercept  (v_in_intercept),
    .a_in_intercept  (a_in_intercept),
    .mem_write_addr  (mem_write_addr),
    .mem_we          (mem_we),
    .mem_write_ready (mem_write_ready),
    .mem_write_done  (mem_write_done),
    .intercept_valid (intercept_valid),
    .feat_v          (feat_v),
    .feat_a          (feat_a),
    .feat_valid      (feat_valid),
    .feat_ready      (feat_ready),
    .in_features     (in_features),
    .fin_valid       (fin_valid),
    .fin_ready       (fin_ready),
    .valence         (valence),
    .arousal         (arousal),
    .dout_valid      (dout_valid),
    .res_valence     (res_valence),
    .res_arousal     (res_arousal),
    .res_valid       (res_valid),
    .res_ready       (res_ready)
  );

  // Synchronous model ROM: row r holds alphas r+16 / r+32 and supports r+1 / r+2.
  logic [7:0]       rom_q = 8'd0;
  logic [NBITS-1:0] v_elem, a_elem;
  always @(posedge clk) if (rom_rd_en) rom_q <= rom_addr;
  assign v_elem        = {1'b0, rom_q} + 9'd1;
  assign a_elem        = {1'b0, rom_q} + 9'd2;
  assign rom_v_support = {VSUP_WIDTH{v_elem}};
  assign rom_a_support = {ASUP_WIDTH{a_elem}};
  assign rom_v_alpha   = {1'b0, rom_q} + 9'd16;
  assign rom_a_alpha   = {1'b0, rom_q} + 9'd32;

  typedef struct {
    logic       ls;
    logic       wr;
    logic       rd_en;
    logic [7:0] raddr;
    logic       we;
    logic [7:0] waddr;
    logic [8:0] valpha;
    logic       done;
    logic       loaded;
    logic       fready;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_feat(input string name, input logic [FEAT_BITS-1:0] act,
                            input logic [FEAT_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got low bits %0h expected low bits %0h", name, act[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t                 vecs[12];
  logic [FEAT_BITS-1:0] fives, minus3s, sevens;
  logic [8:0]           e5, em3, e7;
  logic [8:0]           ev, ea;

  initial begin
    // ls wr rd_en raddr we waddr valpha done loaded fready
    vecs[0]  = '{1, 1, 0, 0, 0, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 1, 1, 0, 0, 0, 0,  0, 0, 0};
    vecs[2]  = '{0, 1, 1, 1, 1, 0, 16, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 2, 1, 1, 17, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 2, 0, 1, 0,  0, 0, 0};
    vecs[5]  = '{0, 0, 0, 2, 0, 1, 0,  0, 0, 0};
    vecs[6]  = '{0, 1, 1, 2, 0, 1, 0,  0, 0, 0};
    vecs[7]  = '{0, 1, 1, 3, 1, 2, 18, 0, 0, 0};
    vecs[8]  = '{0, 1, 0, 3, 1, 3, 19, 0, 0, 0};
    vecs[9]  = '{0, 1, 0, 3, 0, 3, 0,  1, 0, 0};
    vecs[10] = '{0, 1, 0, 3, 0, 3, 0,  0, 1, 1};
    vecs[11] = '{1, 1, 0, 3, 0, 3, 0,  0, 1, 1};

    e5 = 9'd5; em3 = 9'h1FD; e7 = 9'd7;
    fives   = {F_WIDTH{e5}};
    minus3s = {F_WIDTH{em3}};
    sevens  = {F_WIDTH{e7}};

    rst_n = 1'b0; load_start = 1'b0; mem_write_ready = 1'b0;
    cfg_v_intercept = 26'h2ABCDEF; cfg_a_intercept = 26'h1555555;
    feat_v = '0; feat_a = '0; feat_valid = 1'b0; fin_ready = 1'b0;
    valence = 1'b0; arousal = 1'b0; dout_valid = 1'b0; res_ready = 1'b0;

    step(); step();
    check("rst_svm_rst", svm_rst, 1);
    check("rst_rd_en", rom_rd_en, 0);
    check("rst_we", mem_we, 0);
    check("rst_loaded", loaded, 0);
    check("rst_feat_ready", feat_ready, 0);
    check("rst_fin_valid", fin_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", mem_write_done, 0);
    check_feat("rst_in_features", in_features, '0);
    rst_n = 1'b1;
    step();
    check("run_svm_rst", svm_rst, 0);

    // Load with a three-cycle stall after the second read, then ignored load_start.
    for (int i = 0; i < 12; i++) begin
      load_start      = vecs[i].ls;
      mem_write_ready = vecs[i].wr;
      #1;
      ev = vecs[i].valpha;
      ea = vecs[i].we ? vecs[i].valpha + 9'd16 : 9'd0;
      check($sformatf("row%0d_rd_en", i), rom_rd_en, vecs[i].rd_en);
      check($sformatf("row%0d_rom_addr", i), rom_addr, vecs[i].raddr);
      check($sformatf("row%0d_we", i), mem_we, vecs[i].we);
      check($sformatf("row%0d_waddr", i), mem_write_addr, vecs[i].waddr);
      check($sformatf("row%0d_v_alpha", i), v_in_alpha, ev);
      check($sformatf("row%0d_a_alpha", i), a_in_alpha, ea);
      check($sformatf("row%0d_done", i), mem_write_done, vecs[i].done);
      check($sformatf("row%0d_icpt_valid", i), intercept_valid, vecs[i].done);
      check($sformatf("row%0d_loaded", i), loaded, vecs[i].loaded);
      check($sformatf("row%0d_feat_ready", i), feat_ready, vecs[i].fready);
      check($sformatf("row%0d_v_icpt", i), v_in_intercept,
            (vecs[i].done || vecs[i].loaded) ? cfg_v_intercept : '0);
      if (vecs[i].we) begin
        ev = vecs[i].waddr + 9'd1;
        ea = vecs[i].waddr + 9'd2;
        checks++;
        if (v_in_support !== {VSUP_WIDTH{ev}} || a_in_support !== {ASUP_WIDTH{ea}}) begin
          errors++;
          $display("[TB] FAIL row%0d_support: got %0h/%0h expected %0h/%0h",
                   i, v_in_support[8:0], a_in_support[8:0], ev, ea);
        end
      end
      step();
    end
    load_start = 1'b0;
    check("post_ready_rd_en", rom_rd_en, 0);
    check("post_ready_loaded", loaded, 1);
    check("post_a_icpt", a_in_intercept, cfg_a_intercept);

    // Feature handoff with fin_ready held off for two cycles.
    feat_v = fives; feat_a = minus3s; feat_valid = 1'b1;
    #1;
    check("fh_feat_ready", feat_ready, 1);
    step();
    feat_valid = 1'b0; feat_v = sevens; feat_a = sevens;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("fh_v_valid", fin_valid, 1);
      check_feat("fh_v_hold", in_features, fives);
      check("fh_v_feat_ready", feat_ready, 0);
      step();
    end
    fin_ready = 1'b1;
    #1;
    check_feat("fh_v_accept", in_features, fives);
    step();
    fin_ready = 1'b1; dout_valid = 1'b1; valence = 1'b0; arousal = 1'b1;
    #1;
    check("fh_a_valid", fin_valid, 1);
    check_feat("fh_a_data", in_features, minus3s);
    check("fh_a_feat_ready", feat_ready, 0);
    step();
    fin_ready = 1'b0; dout_valid = 1'b0;
    #1;
    check("wr_fin_valid", fin_valid, 0);
    check("wr_res_valid_early", res_valid, 0);
    check_feat("wr_in_features", in_features, '0);
    step();

    // Result held under backpressure.
    dout_valid = 1'b1; valence = 1'b1; arousal = 1'b0; res_ready = 1'b0;
    step();
    dout_valid = 1'b0; valence = 1'b0; arousal = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_res_valid", res_valid, 1);
      check("bp_res_valence", res_valence, 1);
      check("bp_res_arousal", res_arousal, 0);
      check("bp_feat_ready", feat_ready, 0);
      step();
    end
    res_ready = 1'b1; feat_valid = 1'b1;
    #1;
    check("hs_res_valid", res_valid, 1);
    check("hs_feat_ready", feat_ready, 0);
    step();
    res_ready = 1'b0;
    #1;
    check("hs_after_res_valid", res_valid, 0);
    check("hs_after_feat_ready", feat_ready, 1);
    step();
    feat_valid = 1'b0;
    #1;
    check("next_fin_valid", fin_valid, 1);
    check_feat("next_in_features", in_features, sevens);

    // Reset in the middle of a reload.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; load_start = 1'b1; mem_write_ready = 1'b1;
    step();
    load_start = 1'b0;
    step(); step(); step();
    check("ml_we", mem_we, 1);
    check("ml_waddr", mem_write_addr, 2);
    rst_n = 1'b0;
    #1;
    check("ml_svm_rst", svm_rst, 1);
    step();
    check("ml_rd_en", rom_rd_en, 0);
    check("ml_we_clr", mem_we, 0);
    check("ml_waddr_clr", mem_write_addr, 0);
    check("ml_v_alpha", v_in_alpha, 0);
    check("ml_loaded", loaded, 0);
    check("ml_v_icpt", v_in_intercept, 0);
    check("ml_fin_valid", fin_valid, 0);
    check_feat("ml_in_features", in_features, '0);
    rst_n = 1'b1; load_start = 1'b1;
    step();
    load_start = 1'b0;
    #1;
    check("rl_rd_en", rom_rd_en, 1);
    check("rl_rom_addr", rom_addr, 0);
    step();
    check("rl_we", mem_we, 1);
    check("rl_waddr", mem_write_addr, 0);
    check("rl_v_alpha", v_in_alpha, 16);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svm_host_driver.md
Name: svm_host_driver

Overview:
- Host-side initiator for the SVM classifier core; drives the other end of the core's model-load and inference interfaces.
- Model-load phase: reads model rows from an external synchronous model ROM and writes them into the core's SRAM port. Then issues the intercepts and the write-done strobe.
- Inference phase: accepts one valence/arousal feature-vector pair from upstream and presents the two vectors to the core in order.
- The core's result is captured into a one-entry output buffer with a valid/ready handshake, because the core never stalls its own result.

Parameters:
- NBITS, 9, signed quantisation width.
- VSUP_WIDTH, 120, valence support vector count.
- ASUP_WIDTH, 155, arousal support vector count.
- F_WIDTH, 214, number of features.
- LOG_SUP_WIDTH, `ceilLog2(max(VSUP_WIDTH,ASUP_WIDTH)), intercept width term.
- MEM_DEPTH, 214, number of model rows to load (1..256).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- svm_rst  out  1  active-high reset to the core; equals ~rst_n (combinational)
- load_start  in  1  one-cycle request to begin the model load
- loaded  out  1  high once mem_write_done has been issued
- rom_addr  out  8  model ROM read address
- rom_rd_en  out  1  ROM read enable; data returns 1 cycle later
- rom_v_support  in  NBITS*VSUP_WIDTH  ROM data, valence support row
- rom_v_alpha  in  NBITS  ROM data, valence alpha
- rom_a_support  in  NBITS*ASUP_WIDTH  ROM data, arousal support row
- rom_a_alpha  in  NBITS  ROM data, arousal alpha
- cfg_v_intercept  in  2*NBITS+LOG_SUP_WIDTH  static valence intercept
- cfg_a_intercept  in  2*NBITS+LOG_SUP_WIDTH  static arousal intercept
- v_in_support, v_in_alpha, a_in_support, a_in_alpha  out  widths as ROM  core write data
- v_in_intercept, a_in_intercept  out  as cfg  core intercepts
- mem_write_addr  out  8  core write address
- mem_we  out  1  core write enable
- mem_write_ready  in  1  core in write state
- mem_write_done  out  1  one-cycle end-of-load strobe
- intercept_valid  out  1  one-cycle intercept strobe
- feat_v, feat_a  in  NBITS*F_WIDTH each  upstream feature pair
- feat_valid  in  1  upstream valid
- feat_ready  out  1  upstream ready
- in_features  out  NBITS*F_WIDTH  core feature bus
- fin_valid  out  1  core feature valid
- fin_ready  in  1  core feature ready
- valence, arousal, dout_valid  in  1 each  core result
- res_valence, res_arousal  out  1 each  buffered result
- res_valid  out  1  result valid
- res_ready  in  1  downstream ready

Behaviour:
- Single clock clk. Reset is synchronous and active-low (rst_n). While rst_n=0, svm_rst=1.
- Reset values: all strobes, valids, rom_rd_en, loaded, and feat_ready are 0. State is IDLE_UNLOADED; address counters are 0. Output data buses are 0.
- States:
  - IDLE_UNLOADED: on load_start && mem_write_ready -> LOAD. load_start is ignored in every other state; a reload requires a reset.
  - LOAD: issue a read at rom_addr = rd_cnt each cycle mem_write_ready=1; rd_cnt runs 0..MEM_DEPTH-1. Stall with no read if mem_write_ready=0.
    - ROM data from a read issued in cycle t drives v_in_*/a_in_* in cycle t+1, with mem_we=1 and mem_write_addr = the address read in cycle t.
    - Write data is passed through unregistered from the ROM outputs; write address and mem_we are registered.
    - After the last read -> DONE.
  - DONE: entered the cycle after the final mem_we. mem_write_done=1 and intercept_valid=1 for exactly that cycle; v_in_intercept/a_in_intercept hold cfg values continuously. Next state READY, loaded=1.
  - READY: feat_ready=1. On feat_valid && feat_ready, latch feat_v and feat_a -> SEND_V.
  - SEND_V: fin_valid=1, in_features=latched feat_v. On fin_ready -> SEND_A.
  - SEND_A: fin_valid=1, in_features=latched feat_a. On fin_ready -> WAIT_RES.
  - WAIT_RES: on dout_valid, capture valence/arousal into res_* and set res_valid=1 -> HOLD.
  - HOLD: res_valid stays 1 until res_valid && res_ready, then -> READY. feat_ready stays 0, so at most one inference is in flight and the buffer cannot overflow.
- A dout_valid outside WAIT_RES is ignored.
- A feat_valid that coincides with the res_ready handshake is not accepted until the following cycle (READY).
- Total writes = MEM_DEPTH. Addresses are strictly increasing with no gaps or duplicates, even across stalls.
- No arithmetic beyond the 8-bit counters. Sizes are checked at elaboration: MEM_DEPTH must be ≤256.

Decomposition:
- Package svm_pkg holds:
  - NBITS
  - the width localparams
  - the state enum (IDLE_UNLOADED, LOAD, DONE, READY, SEND_V, SEND_A, WAIT_RES, HOLD)
  - the ceilLog2 helper
- One natural sub-module, svm_rom_loader: the LOAD/DONE read/write address pipeline with stall handling. It is reusable for other model-SRAM clients.

Test Plan:
- Load sequence: MEM_DEPTH=4, mem_write_ready=1, pulse load_start.
  - Expect rom_addr 0,1,2,3 on consecutive cycles, then mem_we with addr 0..3 one cycle later each.
  - Expect mem_write_done and intercept_valid together for one cycle after write 3, then loaded=1.
- Load stall: hold mem_write_ready=0 for 3 cycles after the second read.
  - Expect no new reads during the stall and writes at addresses exactly 0..3 with no duplicates.
- Feature handoff: feature pair v=all 5, a=all -3; fin_ready low 2 cycles, then high.
  - Expect in_features=5s held stable until accepted, then -3s; feat_ready low throughout.
- Result backpressure: dout_valid with valence=1, arousal=0 while res_ready=0 for 4 cycles.
  - Expect res_valid held with res_valence=1, res_arousal=0; READY is re-entered only after the handshake.
- Reset mid-LOAD: drop rst_n at write address 2.
  - Expect svm_rst=1, all outputs 0, state IDLE_UNLOADED; a new load restarts at address 0.
- Ignored load_start: pulse load_start in READY.
  - Expect no ROM reads and loaded stays 1.
